// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the bus masters and the arbiter.
// req/lock are levels from the masters; everything else is a registered arbiter output.
interface bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] lock;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic            busy;
  logic            preempt;
  logic [3:0]      hold_cnt;
  logic [1:0]      state;

  // Handshake: a master holds req high until it is done with the bus. It may
  // drive the shared bus only while its grant bit is high. Dropping req ends
  // ownership at the next edge. lock matters only while the master owns the bus.
  modport master (
    output req, lock,
    input  grant, grant_idx, busy, preempt, hold_cnt, state
  );

  modport slave (
    input  req, lock,
    output grant, grant_idx, busy, preempt, hold_cnt, state
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared tri-state bus. It inserts one dead GAP
// cycle between owners and can preempt an owner that holds the bus too long.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDXW     = $clog2(NREQ)
) (
  input  logic        clk,
  input  logic        rst,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [31:0]     HOLD_LIM = 32'(MAX_HOLD - 1);
  localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] ptr;
  logic            preempt;
  logic [3:0]      hold_cnt;

  logic [IDXW-1:0] win;
  logic [IDXW-1:0] win_next;
  logic            found;
  logic [IDXW:0]   cand;
  logic            others_req;
  logic            hold_expired;

  // Scan from ptr and wrap explicitly, because NREQ need not be a power of two.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (!found && bus.req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDXW-1:0];
      end
    end
  end

  assign win_next     = (win == IDXW'(NREQ - 1)) ? '0 : win + IDXW'(1);
  assign others_req   = |(bus.req & ~(ONE << grant_idx));
  assign hold_expired = 32'(hold_cnt) >= HOLD_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (found) begin
            grant     <= ONE << win;
            grant_idx <= win;
            ptr       <= win_next;
            hold_cnt  <= '0;
            state     <= OWN;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          if (hold_cnt != 4'd15) hold_cnt <= hold_cnt + 4'd1;
          // A release wins over a preempt on the same edge, so no preempt pulse then.
          if (!bus.req[grant_idx]) begin
            grant <= '0;
            state <= GAP;
          end else if (!bus.lock[grant_idx] && hold_expired && others_req) begin
            grant   <= '0;
            preempt <= 1'b1;
            state   <= GAP;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant;
  assign bus.grant_idx = grant_idx;
  assign bus.busy      = |grant;
  assign bus.preempt   = preempt;
  assign bus.hold_cnt  = hold_cnt;
  assign bus.state     = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter with NREQ=4 and MAX_HOLD=4: directed scenarios,
// a per-cycle grant scoreboard, and bus-safety monitors.
module tb_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_arbiter_if #(.NREQ(NREQ)) bus ();

  bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [NREQ-1:0] exp_q[$];
  logic [NREQ-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Safety monitor: at most one driver, and an idle cycle between different owners.
  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    check("turnaround",
          32'((prev_grant == '0) || (bus.grant == '0) || (bus.grant == prev_grant)), 32'd1);
    prev_grant = bus.grant;
  end

  task automatic do_reset();
    bus.req  = '0;
    bus.lock = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_preempt", 32'(bus.preempt), 32'd0);
    check("rst_hold", 32'(bus.hold_cnt), 32'd0);
    check("rst_idx", 32'(bus.grant_idx), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs, then score the grant seen after the next edge.
  task automatic cyc(input string tag, input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                     input logic [NREQ-1:0] g);
    logic [NREQ-1:0] e;
    bus.req  = r;
    bus.lock = l;
    exp_q.push_back(g);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, 32'(bus.grant), 32'(e));
  endtask

  initial begin
    bus.req  = '0;
    bus.lock = '0;

    // 1: async reset in the middle of an ownership
    do_reset();
    cyc("s1_own1", 4'b0010, 4'b0000, 4'b0010);
    cyc("s1_own1b", 4'b0010, 4'b0000, 4'b0010);
    #3;
    rst = 1'b1;
    #1;
    check("s1_async_grant", 32'(bus.grant), 32'd0);
    check("s1_async_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0001;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("s1_first", 4'b0001, 4'b0000, 4'b0001);
    check("s1_idx", 32'(bus.grant_idx), 32'd0);
    cyc("s1_rel", 4'b0000, 4'b0000, 4'b0000);

    // 2: round robin with all masters requesting
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      cyc("s2_grant", 4'b1111, 4'b0000, 4'(1 << k));
      check("s2_idx", 32'(bus.grant_idx), 32'(k));
      check("s2_busy", 32'(bus.busy), 32'd1);
      cyc("s2_hold", 4'b1111, 4'b0000, 4'(1 << k));
      cyc("s2_gap", 4'b1111 & ~4'(1 << k), 4'b0000, 4'b0000);
    end
    cyc("s2_wrap", 4'b1111, 4'b0000, 4'b0001);
    cyc("s2_end", 4'b0000, 4'b0000, 4'b0000);

    // 3: hold limit preempts an unlocked owner
    do_reset();
    cyc("s3_own", 4'b0001, 4'b0000, 4'b0001);
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      cyc("s3_hold", 4'b0101, 4'b0000, 4'b0001);
      check("s3_nopre", 32'(bus.preempt), 32'd0);
    end
    cyc("s3_pre", 4'b0101, 4'b0000, 4'b0000);
    check("s3_prepulse", 32'(bus.preempt), 32'd1);
    cyc("s3_next", 4'b0101, 4'b0000, 4'b0100);
    check("s3_preoff", 32'(bus.preempt), 32'd0);
    check("s3_idx", 32'(bus.grant_idx), 32'd2);
    cyc("s3_rel", 4'b0000, 4'b0000, 4'b0000);

    // 4: locked owner is never preempted and hold_cnt saturates
    do_reset();
    cyc("s4_own", 4'b0001, 4'b0001, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      cyc("s4_hold", 4'b0101, 4'b0001, 4'b0001);
      check("s4_nopre", 32'(bus.preempt), 32'd0);
    end
    check("s4_sat", 32'(bus.hold_cnt), 32'd15);
    cyc("s4_rel", 4'b0100, 4'b0001, 4'b0000);
    cyc("s4_next", 4'b0100, 4'b0000, 4'b0100);
    cyc("s4_end", 4'b0000, 4'b0000, 4'b0000);

    // 5: release on the same edge as the preempt condition
    do_reset();
    cyc("s5_own", 4'b0001, 4'b0000, 4'b0001);
    for (int k = 0; k < MAX_HOLD - 1; k++)
      cyc("s5_hold", 4'b0101, 4'b0000, 4'b0001);
    cyc("s5_rel", 4'b0100, 4'b0000, 4'b0000);
    check("s5_nopre", 32'(bus.preempt), 32'd0);
    cyc("s5_next", 4'b0100, 4'b0000, 4'b0100);
    cyc("s5_end", 4'b0000, 4'b0000, 4'b0000);

    // 6: one-cycle request glitch is never granted
    do_reset();
    cyc("s6_own", 4'b0001, 4'b0000, 4'b0001);
    cyc("s6_glitch", 4'b1001, 4'b0000, 4'b0001);
    cyc("s6_gap", 4'b0000, 4'b0000, 4'b0000);
    cyc("s6_idle", 4'b0000, 4'b0000, 4'b0000);
    check("s6_state", 32'(bus.state), 32'd0);
    check("s6_busy", 32'(bus.busy), 32'd0);
    check("s6_idx_hold", 32'(bus.grant_idx), 32'd0);
    cyc("s6_idle2", 4'b0000, 4'b0000, 4'b0000);

    // Random request traffic: only the safety monitors check this phase.
    for (int k = 0; k < 200; k++) begin
      bus.req  = 4'($urandom_range(0, 15));
      bus.lock = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
